// File: rtl/xyz_debug_scan_pkg.sv
// Purpose : shared types and helpers for the debug scan bridge.
// Latency : n/a (declarations only).
// Backpres: n/a.
// Contents: FSM state enum, ir_out status bit positions, parity helper.
package xyz_debug_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PEND  = 2'd2
  } scan_state_e;

  // Status bits reported back to the JTAG hub on ir_out.
  localparam int unsigned STAT_ACT_BIT = 0;
  localparam int unsigned STAT_OVR_BIT = 1;

  // Callers zero-extend their vector to this width; the extra zeros
  // leave the parity unchanged.
  localparam int unsigned PAR_MAX_W = 256;

  function automatic logic parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/xyz_debug_scan_bridge_if.sv
// Purpose : action handshake from the scan bridge to the CPU debug logic.
// Latency : n/a (wires only).
// Backpres: act_valid holds with jdo/act_ch stable until act_ready is seen.
// Ports   : jdo (update word), act_ch (channel), act_valid, act_ready.
interface xyz_debug_scan_bridge_if #(
  parameter int DR_W = 38,
  parameter int IR_W = 2
);
  logic [DR_W-1:0] jdo;
  logic [IR_W-1:0] act_ch;
  logic            act_valid;
  logic            act_ready;

  modport master (output jdo, output act_ch, output act_valid, input act_ready);
  modport slave  (input jdo, input act_ch, input act_valid, output act_ready);
endinterface

// File: rtl/xyz_debug_scan_sr.sv
// Purpose : DR_W-bit scan data register with per-channel capture mux and LSB-first shift.
// Latency : sr updates one clk after cap_en/shift_en; sr_d exposes the next value combinationally.
// Backpres: none; capture wins over shift when both are requested.
// Ports   : clk/reset, cap_en, shift_en, tdi, sel (channel), rd_data, tdo (= sr[0]), sr_d.
// Macro   : XYZ_DEBUG_SCAN_PARITY_EN makes capture fill the MSB with even parity.
module xyz_debug_scan_sr
  import xyz_debug_scan_pkg::*;
#(
  parameter int DR_W = 38,
  parameter int IR_W = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cap_en,
  input  logic                          shift_en,
  input  logic                          tdi,
  input  logic [IR_W-1:0]               sel,
  input  logic [(2**IR_W)*DR_W-1:0]     rd_data,
  output logic                          tdo,
  output logic [DR_W-1:0]               sr_d
);

  logic [DR_W-1:0] sr_q;
  logic [DR_W-1:0] cap_word;

  always_comb begin
    cap_word = rd_data[int'(sel)*DR_W +: DR_W];
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
    cap_word[DR_W-1] = parity(PAR_MAX_W'(cap_word[DR_W-2:0]));
`endif
    sr_d = sr_q;
    if (cap_en) begin
      sr_d = cap_word;
    end else if (shift_en) begin
      sr_d = {tdi, sr_q[DR_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign tdo = sr_q[0];

endmodule

// File: rtl/xyz_debug_scan_bridge.sv
// Purpose : virtual-JTAG debug scan bridge: capture/shift a DR and post update words as actions.
// Latency : act_valid rises the cycle after vs_udr; ir_out lags status by one cycle.
// Backpres: one action buffered; an update while the action is unaccepted is dropped and sets overrun.
// Ports   : clk, reset, ir_in/ir_out, vs_uir/vs_cdr/vs_sdr/vs_udr, tdi/tdo, rd_data,
//           act_if (jdo, act_ch, act_valid, act_ready), overrun, ovr_clr, [perr].
// Macro   : XYZ_DEBUG_SCAN_PARITY_EN adds the DR parity check and the perr output.
module xyz_debug_scan_bridge
  import xyz_debug_scan_pkg::*;
#(
  parameter int DR_W   = 38,
  parameter int IR_W   = 2,
  parameter int RST_IR = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [IR_W-1:0]               ir_in,
  output logic [IR_W-1:0]               ir_out,
  input  logic                          vs_uir,
  input  logic                          vs_cdr,
  input  logic                          vs_sdr,
  input  logic                          vs_udr,
  input  logic                          tdi,
  output logic                          tdo,
  input  logic [(2**IR_W)*DR_W-1:0]     rd_data,
  output logic                          overrun,
  input  logic                          ovr_clr,
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
  output logic                          perr,
`endif
  xyz_debug_scan_bridge_if.master       act_if
);

  scan_state_e     state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] act_ch_q, act_ch_d;
  logic [IR_W-1:0] ir_out_q, ir_out_d;
  logic [DR_W-1:0] jdo_q, jdo_d;
  logic [DR_W-1:0] sr_d;
  logic            act_valid_q, act_valid_d;
  logic            overrun_q, overrun_d;
  logic            err_flag;
  logic            hs, cap_en, shift_en, udr_en;
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
  logic            perr_q, perr_d;
  logic            word_ok;
  assign err_flag = overrun_q | perr_q;
  // Even parity across the whole word, including the shift applied this cycle.
  assign word_ok  = ~parity(PAR_MAX_W'(sr_d));
`else
  assign err_flag = overrun_q;
`endif

  xyz_debug_scan_sr #(.DR_W(DR_W), .IR_W(IR_W)) u_sr (
    .clk      (clk),
    .reset    (reset),
    .cap_en   (cap_en),
    .shift_en (shift_en),
    .tdi      (tdi),
    .sel      (ir_q),
    .rd_data  (rd_data),
    .tdo      (tdo),
    .sr_d     (sr_d)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    jdo_d       = jdo_q;
    act_ch_d    = act_ch_q;
    act_valid_d = act_valid_q;
    overrun_d   = overrun_q & ~ovr_clr;
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
    perr_d      = perr_q & ~ovr_clr;
`endif
    hs = act_valid_q & act_if.act_ready;
    // Strobe priority uir > cdr > sdr/udr; sdr and udr combine (shift, then latch).
    cap_en   = ~vs_uir & vs_cdr;
    shift_en = ~vs_uir & ~vs_cdr & vs_sdr & (state_q != IDLE);
    udr_en   = ~vs_uir & ~vs_cdr & vs_udr & (state_q != IDLE);
    if (vs_uir) ir_d = ir_in;

    ir_out_d               = '0;
    ir_out_d[STAT_ACT_BIT] = act_valid_q;
    ir_out_d[STAT_OVR_BIT] = err_flag;

    case (state_q)
      IDLE: begin
        if (cap_en) state_d = SHIFT;
      end
      SHIFT: begin
        if (udr_en) begin
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
          if (!word_ok) begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end else
`endif
          begin
            jdo_d       = sr_d;
            act_ch_d    = ir_q;
            act_valid_d = 1'b1;
            state_d     = PEND;
          end
        end
      end
      PEND: begin
        if (hs) begin
          act_valid_d = 1'b0;
          state_d     = cap_en ? SHIFT : IDLE;
        end
        if (udr_en) begin
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
          if (!word_ok) begin
            perr_d = 1'b1;
          end else
`endif
          if (hs) begin
            // Slot frees this cycle, so the new word takes it directly.
            jdo_d       = sr_d;
            act_ch_d    = ir_q;
            act_valid_d = 1'b1;
            state_d     = PEND;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ir_q        <= IR_W'(RST_IR);
      jdo_q       <= '0;
      act_ch_q    <= '0;
      act_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      ir_out_q    <= '0;
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      jdo_q       <= jdo_d;
      act_ch_q    <= act_ch_d;
      act_valid_q <= act_valid_d;
      overrun_q   <= overrun_d;
      ir_out_q    <= ir_out_d;
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  assign act_if.jdo       = jdo_q;
  assign act_if.act_ch    = act_ch_q;
  assign act_if.act_valid = act_valid_q;
  assign overrun          = overrun_q;
  assign ir_out           = ir_out_q;
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
  assign perr             = perr_q;
`endif

endmodule

// File: tb/tb_xyz_debug_scan_bridge.sv
// Purpose : self-checking bench for xyz_debug_scan_bridge (directed scenarios + random traffic).
// Latency : expectations come from a bit-queue reference model updated at each clk edge.
// Backpres: act_ready driven directly by the bench.
module tb_xyz_debug_scan_bridge;
  localparam int DR_W   = 38;
  localparam int IR_W   = 2;
  localparam int NUM_CH = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [IR_W-1:0]          ir_in;
  logic [IR_W-1:0]          ir_out;
  logic                     vs_uir, vs_cdr, vs_sdr, vs_udr, tdi, tdo;
  logic [NUM_CH*DR_W-1:0]   rd_data;
  logic                     overrun, ovr_clr;
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
  logic                     perr;
`endif

  always #5 clk = ~clk;

  xyz_debug_scan_bridge_if #(.DR_W(DR_W), .IR_W(IR_W)) act_if ();

  xyz_debug_scan_bridge #(.DR_W(DR_W), .IR_W(IR_W), .RST_IR(0)) dut (
    .clk     (clk),
    .reset   (reset),
    .ir_in   (ir_in),
    .ir_out  (ir_out),
    .vs_uir  (vs_uir),
    .vs_cdr  (vs_cdr),
    .vs_sdr  (vs_sdr),
    .vs_udr  (vs_udr),
    .tdi     (tdi),
    .tdo     (tdo),
    .rd_data (rd_data),
    .overrun (overrun),
    .ovr_clr (ovr_clr),
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
    .perr    (perr),
`endif
    .act_if  (act_if)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: DR kept as a bit queue, index 0 is the bit nearest tdo.
  bit              m_q[$];
  logic [IR_W-1:0] m_ir;
  logic [DR_W-1:0] m_jdo;
  logic [IR_W-1:0] m_ch;
  logic [IR_W-1:0] m_irout;
  bit              m_av, m_ovr, m_perr, m_pend, m_scan;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ones(input logic [DR_W-1:0] v);
    int n = 0;
    for (int i = 0; i < DR_W; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [DR_W-1:0] m_word();
    logic [DR_W-1:0] w;
    for (int i = 0; i < DR_W; i++) w[i] = m_q[i];
    return w;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < DR_W; i++) m_q.push_back(1'b0);
    m_ir = '0; m_jdo = '0; m_ch = '0; m_irout = '0;
    m_av = 0; m_ovr = 0; m_perr = 0; m_pend = 0; m_scan = 0;
  endtask

  task automatic model_capture();
    logic [DR_W-1:0] w;
    w = rd_data[int'(m_ir)*DR_W +: DR_W];
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
    w[DR_W-1] = 1'b0;
    w[DR_W-1] = ((ones(w) % 2) == 1);
`endif
    m_q.delete();
    for (int i = 0; i < DR_W; i++) m_q.push_back(w[i]);
  endtask

  task automatic model_edge();
    bit hs, was_pend, upd, cap;
    logic [DR_W-1:0] w;
    hs       = m_av && (act_if.act_ready === 1'b1);
    was_pend = m_pend;
    upd = 0; cap = 0;
    m_irout    = '0;
    m_irout[0] = m_av;
    m_irout[1] = m_ovr || m_perr;
    if (vs_uir) m_ir = ir_in;
    else if (vs_cdr) begin model_capture(); cap = 1; end
    else if (m_scan || m_pend) begin
      if (vs_sdr) begin void'(m_q.pop_front()); m_q.push_back(tdi); end
      upd = vs_udr;
    end
    m_ovr  = m_ovr  && !ovr_clr;
    m_perr = m_perr && !ovr_clr;
    if (hs) begin m_av = 0; m_pend = 0; m_scan = cap; end
    else if (cap) m_scan = 1;
    if (upd) begin
      w = m_word();
      m_scan = 0;
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
      if ((ones(w) % 2) == 1) m_perr = 1;
      else
`endif
      if (was_pend && !hs) m_ovr = 1;
      else begin m_jdo = w; m_ch = m_ir; m_av = 1; m_pend = 1; end
    end
  endtask

  task automatic check_all();
    check("tdo",       64'(tdo),              64'(m_q[0]));
    check("jdo",       64'(act_if.jdo),       64'(m_jdo));
    check("act_ch",    64'(act_if.act_ch),    64'(m_ch));
    check("act_valid", 64'(act_if.act_valid), 64'(m_av));
    check("overrun",   64'(overrun),          64'(m_ovr));
    check("ir_out",    64'(ir_out),           64'(m_irout));
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
    check("perr",      64'(perr),             64'(m_perr));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0; ovr_clr = 0;
  endtask

  task automatic shift_in(input logic [DR_W-1:0] w);
    for (int i = 0; i < DR_W; i++) begin
      tdi = w[i]; vs_sdr = 1; step();
    end
    tdi = 0;
  endtask

  logic [DR_W-1:0] ch2_w, exp_w, word;

  initial begin
    reset = 1; ir_in = '0; vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0;
    tdi = 0; ovr_clr = 0; act_if.act_ready = 0;
    for (int k = 0; k < NUM_CH; k++) rd_data[k*DR_W +: DR_W] = DR_W'({$urandom(), $urandom()});
    ch2_w = 38'h2_1234_5678;
    rd_data[2*DR_W +: DR_W] = ch2_w;
    exp_w = ch2_w;
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
    exp_w[DR_W-1] = ^exp_w[DR_W-2:0];
`endif
    model_reset();
    #12;
    check_all();
    check("rst_ir_out", 64'(ir_out), 64'(0));
    reset = 0;

    // Select channel 2, capture, read it out LSB-first.
    ir_in = 2; vs_uir = 1; step();
    vs_cdr = 1; step();
    for (int i = 0; i < DR_W; i++) begin
      check("t1_tdo", 64'(tdo), 64'(exp_w[i]));
      tdi = 0; vs_sdr = 1; step();
    end

`ifdef XYZ_DEBUG_SCAN_PARITY_EN
    // Odd-parity word is rejected with perr.
    shift_in(38'h3_0000_00AB);
    vs_udr = 1; step();
    check("par_bad_av", 64'(act_if.act_valid), 64'(0));
    check("par_bad_perr", 64'(perr), 64'(1));
    ovr_clr = 1; step();
    vs_cdr = 1; step();
    word = 38'h1_0000_00AB;
`else
    word = 38'h3_0000_00AB;
`endif
    shift_in(word);
    vs_udr = 1; step();
    check("t2_av", 64'(act_if.act_valid), 64'(1));
    check("t2_jdo", 64'(act_if.jdo), 64'(word));
    check("t2_ch", 64'(act_if.act_ch), 64'(2));
    act_if.act_ready = 1; step(); act_if.act_ready = 0;
    check("t2_av_drop", 64'(act_if.act_valid), 64'(0));

    // Overrun: second update while the first is unaccepted.
    vs_cdr = 1; step();
    vs_udr = 1; step();
    check("t3_av", 64'(act_if.act_valid), 64'(1));
    vs_udr = 1; step();
    check("t3_ovr", 64'(overrun), 64'(1));
    check("t3_jdo", 64'(act_if.jdo), 64'(exp_w));
    step();
    check("t3_ir_out", 64'(ir_out), 64'(3));
    ovr_clr = 1; step();
    check("t3_ovr_clr", 64'(overrun), 64'(0));

    // Update with handshake in the same cycle replaces the word.
    word = 38'h0_5A5A_C3C3;
`ifdef XYZ_DEBUG_SCAN_PARITY_EN
    word[DR_W-1] = ^word[DR_W-2:0];
`endif
    shift_in(word);
    vs_udr = 1; act_if.act_ready = 1; step(); act_if.act_ready = 0;
    check("t4_av", 64'(act_if.act_valid), 64'(1));
    check("t4_jdo", 64'(act_if.jdo), 64'(word));
    check("t4_ovr", 64'(overrun), 64'(0));
    act_if.act_ready = 1; step(); act_if.act_ready = 0;

    // Async reset mid-shift, then an update in IDLE does nothing.
    vs_cdr = 1; step();
    for (int i = 0; i < 10; i++) begin tdi = 1; vs_sdr = 1; step(); end
    #2 reset = 1;
    model_reset();
    #1;
    check_all();
    check("t5_tdo", 64'(tdo), 64'(0));
    check("t5_jdo", 64'(act_if.jdo), 64'(0));
    #2 reset = 0;
    vs_udr = 1; step();
    check("t5_av", 64'(act_if.act_valid), 64'(0));

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 2) begin
        for (int k = 0; k < NUM_CH; k++) rd_data[k*DR_W +: DR_W] = DR_W'({$urandom(), $urandom()});
      end
      ir_in  = IR_W'($urandom_range(0, NUM_CH-1));
      vs_uir = ($urandom_range(0, 99) < 3);
      vs_cdr = ($urandom_range(0, 99) < 6);
      vs_sdr = ($urandom_range(0, 99) < 50);
      vs_udr = ($urandom_range(0, 99) < 10);
      tdi    = 1'($urandom_range(0, 1));
      ovr_clr = ($urandom_range(0, 99) < 4);
      act_if.act_ready = ($urandom_range(0, 99) < 30);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
